stack_ctrl: RTL and testbench

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/stack_pkg.sv | 32 +++
 rtl/stack_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_stack_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared encodings for the nibble stack controller: FSM states, request
// types and the default stack capacity.
package stack_pkg;

    localparam int DEPTH_MAX_DEF = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEC,
        S_WR,
        S_RD,
        S_INC,
        S_FIN
    } state_t;

    typedef enum logic [1:0] {
        OP_PUSH,
        OP_POP,
        OP_CALL,
        OP_RET
    } op_t;

    // Nibbles moved by one request: CALL/RET move a full 8-bit address.
    function automatic logic [9:0] op_nibs(input op_t op);
        return (op == OP_CALL || op == OP_RET) ? 10'd2 : 10'd1;
    endfunction

    function automatic logic op_is_write(input op_t op);
        return (op == OP_PUSH || op == OP_CALL);
    endfunction

endpackage

// File: rtl/stack_ctrl.sv
// Nibble stack controller: sequences SP strobes and STOREBUS transfers for
// PUSH/POP/CALL/RET, tracks stack depth and sticky overflow/underflow flags.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int DEPTH_MAX = DEPTH_MAX_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PUSH_REQ,
    input  logic       POP_REQ,
    input  logic       CALL_REQ,
    input  logic       RET_REQ,
    input  logic [3:0] DATA_IN,
    input  logic [7:0] PC_IN,
    input  logic [3:0] STORE_IN,
    input  logic       ERR_CLR,
    output logic [3:0] STORE_OUT,
    output logic       STORE_OE,
    output logic       nSK_EN,
    output logic       SP_D_nU,
    output logic       SPC,
    output logic       BUSY,
    output logic       DONE,
    output logic [3:0] DATA_OUT,
    output logic [7:0] RET_ADDR,
    output logic [8:0] DEPTH,
    output logic       OVF,
    output logic       UNF
);

    localparam logic [9:0] DMAX = 10'(DEPTH_MAX);

    state_t     state_q, state_d;
    op_t        op_q, op_d;
    logic       nib_q, nib_d;
    logic [8:0] depth_q, depth_d;
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;
    logic [3:0] dout_q, dout_d;
    logic [7:0] raddr_q, raddr_d;
    logic [3:0] wdat_q, wdat_d;
    logic [7:0] pc_q, pc_d;
    logic       dnu_q, dnu_d;

    logic       req_vld;
    op_t        req_op;
    logic       ovf_set, unf_set;
    logic [3:0] wr_nib;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
            op_q    <= OP_PUSH;
            nib_q   <= 1'b0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            dout_q  <= '0;
            raddr_q <= '0;
            wdat_q  <= '0;
            pc_q    <= '0;
            dnu_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            nib_q   <= nib_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            dout_q  <= dout_d;
            raddr_q <= raddr_d;
            wdat_q  <= wdat_d;
            pc_q    <= pc_d;
            dnu_q   <= dnu_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        nib_d     = nib_q;
        depth_d   = depth_q;
        dout_d    = dout_q;
        raddr_d   = raddr_q;
        wdat_d    = wdat_q;
        pc_d      = pc_q;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        req_vld   = 1'b1;
        req_op    = OP_PUSH;
        SPC       = 1'b0;
        nSK_EN    = 1'b1;
        STORE_OE  = 1'b0;
        STORE_OUT = 4'h0;
        SP_D_nU   = dnu_q;

        if (CALL_REQ)      req_op = OP_CALL;
        else if (RET_REQ)  req_op = OP_RET;
        else if (PUSH_REQ) req_op = OP_PUSH;
        else if (POP_REQ)  req_op = OP_POP;
        else               req_vld = 1'b0;

        // CALL sends the high address nibble first so RET pops the low one first.
        wr_nib = (op_q == OP_CALL) ? (nib_q ? pc_q[3:0] : pc_q[7:4]) : wdat_q;

        case (state_q)
            S_IDLE: begin
                if (req_vld) begin
                    op_d   = req_op;
                    nib_d  = 1'b0;
                    wdat_d = DATA_IN;
                    pc_d   = PC_IN;
                    if (op_is_write(req_op)) begin
                        if ({1'b0, depth_q} + op_nibs(req_op) > DMAX) begin
                            ovf_set = 1'b1;
                            state_d = S_FIN;
                        end else begin
                            state_d = S_DEC;
                        end
                    end else begin
                        if ({1'b0, depth_q} < op_nibs(req_op)) begin
                            unf_set = 1'b1;
                            state_d = S_FIN;
                        end else begin
                            state_d = S_RD;
                        end
                    end
                end
            end
            S_DEC: begin
                SPC     = 1'b1;
                SP_D_nU = 1'b1;
                state_d = S_WR;
            end
            S_WR: begin
                nSK_EN    = 1'b0;
                SP_D_nU   = 1'b1;
                STORE_OE  = 1'b1;
                STORE_OUT = wr_nib;
                depth_d   = depth_q + 9'd1;
                if (op_q == OP_CALL && !nib_q) begin
                    nib_d   = 1'b1;
                    state_d = S_DEC;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_RD: begin
                nSK_EN  = 1'b0;
                SP_D_nU = 1'b0;
                if (op_q == OP_RET) begin
                    if (nib_q) raddr_d[7:4] = STORE_IN;
                    else       raddr_d[3:0] = STORE_IN;
                end else begin
                    dout_d = STORE_IN;
                end
                state_d = S_INC;
            end
            S_INC: begin
                SPC     = 1'b1;
                SP_D_nU = 1'b0;
                depth_d = depth_q - 9'd1;
                if (op_q == OP_RET && !nib_q) begin
                    nib_d   = 1'b1;
                    state_d = S_RD;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                nib_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        dnu_d = SP_D_nU;
        // A new error on the same edge as ERR_CLR keeps its flag set.
        ovf_d = ovf_set | (ovf_q & ~ERR_CLR);
        unf_d = unf_set | (unf_q & ~ERR_CLR);
    end

    assign BUSY     = (state_q != S_IDLE);
    assign DONE     = (state_q == S_FIN);
    assign DEPTH    = depth_q;
    assign OVF      = ovf_q;
    assign UNF      = unf_q;
    assign DATA_OUT = dout_q;
    assign RET_ADDR = raddr_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Randomized bench for stack_ctrl: a queue-based stack model predicts every
// output cycle by cycle; a RAM with its own SP stands in for the stack memory.
module tb_stack_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       PUSH_REQ = 1'b0, POP_REQ = 1'b0, CALL_REQ = 1'b0, RET_REQ = 1'b0;
    logic [3:0] DATA_IN = '0;
    logic [7:0] PC_IN = '0;
    logic [3:0] STORE_IN;
    logic       ERR_CLR = 1'b0;
    logic [3:0] STORE_OUT;
    logic       STORE_OE, nSK_EN, SP_D_nU, SPC, BUSY, DONE;
    logic [3:0] DATA_OUT;
    logic [7:0] RET_ADDR;
    logic [8:0] DEPTH;
    logic       OVF, UNF;

    stack_ctrl #(.DEPTH_MAX(256)) dut (
        .CLK(CLK), .RST(RST),
        .PUSH_REQ(PUSH_REQ), .POP_REQ(POP_REQ), .CALL_REQ(CALL_REQ), .RET_REQ(RET_REQ),
        .DATA_IN(DATA_IN), .PC_IN(PC_IN), .STORE_IN(STORE_IN), .ERR_CLR(ERR_CLR),
        .STORE_OUT(STORE_OUT), .STORE_OE(STORE_OE), .nSK_EN(nSK_EN), .SP_D_nU(SP_D_nU),
        .SPC(SPC), .BUSY(BUSY), .DONE(DONE), .DATA_OUT(DATA_OUT), .RET_ADDR(RET_ADDR),
        .DEPTH(DEPTH), .OVF(OVF), .UNF(UNF)
    );

    always #5 CLK = ~CLK;

    // Stack RAM environment with an 8-bit SP that follows the strobes.
    logic [7:0] env_sp;
    logic [3:0] mem [256];
    logic [3:0] junk = 4'h0;
    assign STORE_IN = nSK_EN ? junk : mem[env_sp];

    always @(posedge CLK) begin
        if (!RST) env_sp <= 8'hFF;
        else begin
            if (!nSK_EN && STORE_OE) mem[env_sp] <= STORE_OUT;
            if (SPC) env_sp <= SP_D_nU ? env_sp - 8'd1 : env_sp + 8'd1;
        end
    end
    always @(negedge CLK) junk <= 4'($urandom);

    typedef struct packed {
        logic       busy, done, spc, nsk, oe;
        logic [3:0] sout;
        logic       dnu;
        logic [8:0] depth;
        logic       ovf, unf;
        logic [3:0] dout;
        logic [7:0] raddr;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] m_stk[$];
    logic       m_ovf = 1'b0, m_unf = 1'b0, m_dnu = 1'b0;
    logic [3:0] m_dout = '0;
    logic [7:0] m_raddr = '0;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic exp_t cur_exp();
        exp_t e;
        e       = '0;
        e.busy  = 1'b1;
        e.nsk   = 1'b1;
        e.dnu   = m_dnu;
        e.depth = 9'(m_stk.size());
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.dout  = m_dout;
        e.raddr = m_raddr;
        return e;
    endfunction

    // Compare process: one expected vector per cycle, idle when nothing queued.
    exp_t idle_e, ce;
    always @(posedge CLK) begin
        #1;
        if (chk_en) begin
            if (exp_q.size() > 0) ce = exp_q.pop_front();
            else                  ce = idle_e;
            chk("ctrl", 32'({BUSY, DONE, SPC, nSK_EN, STORE_OE, STORE_OUT, SP_D_nU}),
                32'({ce.busy, ce.done, ce.spc, ce.nsk, ce.oe, ce.sout, ce.dnu}));
            chk("depth", 32'(DEPTH), 32'(ce.depth));
            chk("flags", 32'({OVF, UNF}), 32'({ce.ovf, ce.unf}));
            chk("data_out", 32'(DATA_OUT), 32'(ce.dout));
            chk("ret_addr", 32'(RET_ADDR), 32'(ce.raddr));
            idle_e      = ce;
            idle_e.busy = 1'b0;
            idle_e.done = 1'b0;
            idle_e.spc  = 1'b0;
            idle_e.nsk  = 1'b1;
            idle_e.oe   = 1'b0;
            idle_e.sout = 4'h0;
        end
    end

    task automatic clear_model();
        m_stk.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_dnu = 1'b0;
        m_dout = '0; m_raddr = '0;
    endtask

    // reqs = {CALL, RET, PUSH, POP}; hold keeps the requests up while busy.
    task automatic op(input logic [3:0] reqs, input logic [3:0] d, input logic [7:0] pc,
                      input bit hold, input bit clr);
        exp_t e;
        logic [3:0] nib [2];
        int cnt, n;
        bit wr;
        cnt = 0; wr = 1'b0;
        nib[0] = '0; nib[1] = '0;
        @(negedge CLK);
        {CALL_REQ, RET_REQ, PUSH_REQ, POP_REQ} = reqs;
        DATA_IN = d; PC_IN = pc; ERR_CLR = clr;
        if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
        if (reqs[3])      begin cnt = 2; wr = 1'b1; nib[0] = pc[7:4]; nib[1] = pc[3:0]; end
        else if (reqs[2]) begin cnt = 2; end
        else if (reqs[1]) begin cnt = 1; wr = 1'b1; nib[0] = d; end
        else if (reqs[0]) begin cnt = 1; end

        if (cnt == 0) begin
            e = cur_exp(); e.busy = 1'b0; exp_q.push_back(e);
        end else begin
            if (wr && m_stk.size() + cnt > 256) m_ovf = 1'b1;
            else if (!wr && m_stk.size() < cnt) m_unf = 1'b1;
            else if (wr) begin
                for (int i = 0; i < cnt; i++) begin
                    m_dnu = 1'b1;
                    e = cur_exp(); e.spc = 1'b1; exp_q.push_back(e);
                    e = cur_exp(); e.nsk = 1'b0; e.oe = 1'b1; e.sout = nib[i]; exp_q.push_back(e);
                    m_stk.push_back(nib[i]);
                end
            end else begin
                for (int i = 0; i < cnt; i++) begin
                    m_dnu = 1'b0;
                    e = cur_exp(); e.nsk = 1'b0; exp_q.push_back(e);
                    if (cnt == 2) m_raddr[i*4 +: 4] = m_stk[$];
                    else          m_dout = m_stk[$];
                    e = cur_exp(); e.spc = 1'b1; exp_q.push_back(e);
                    void'(m_stk.pop_back());
                end
            end
            e = cur_exp(); e.done = 1'b1; exp_q.push_back(e);
        end
        n = exp_q.size();
        @(negedge CLK);
        ERR_CLR = 1'b0;
        if (!hold) {CALL_REQ, RET_REQ, PUSH_REQ, POP_REQ} = 4'b0;
        repeat (n - 1) @(negedge CLK);
        {CALL_REQ, RET_REQ, PUSH_REQ, POP_REQ} = 4'b0;
    endtask

    task automatic reset_pulse();
        exp_t e;
        @(negedge CLK);
        RST = 1'b0;
        clear_model();
        e = cur_exp(); e.busy = 1'b0; exp_q.push_back(e);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        exp_t e;
        logic [3:0] mask;
        for (int i = 0; i < 256; i++) mem[i] = 4'h0;
        idle_e     = '0;
        idle_e.nsk = 1'b1;
        repeat (2) @(negedge CLK);
        chk_en = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        // Single push of A, then pop it back.
        op(4'b0010, 4'hA, 8'h00, 1'b0, 1'b0);
        chk("push_depth_lit", 32'(DEPTH), 32'd1);
        chk("model_depth_lit", 32'(m_stk.size()), 32'd1);
        op(4'b0001, 4'h0, 8'h00, 1'b0, 1'b0);
        chk("pop_data_lit", 32'(DATA_OUT), 32'hA);

        // Underflow on empty, then clear.
        op(4'b0001, 4'h0, 8'h00, 1'b0, 1'b0);
        chk("unf_lit", 32'(UNF), 32'd1);
        op(4'b0000, 4'h0, 8'h00, 1'b0, 1'b1);
        chk("unf_clr_lit", 32'(UNF), 32'd0);

        // CALL 3C then RET.
        op(4'b1000, 4'h0, 8'h3C, 1'b0, 1'b0);
        op(4'b0100, 4'h0, 8'h00, 1'b0, 1'b0);
        chk("ret_addr_lit", 32'(RET_ADDR), 32'h3C);
        chk("ret_depth_lit", 32'(DEPTH), 32'd0);

        // CALL and PUSH together, PUSH held through busy.
        op(4'b1010, 4'h5, 8'hE7, 1'b1, 1'b0);
        chk("prio_depth_lit", 32'(DEPTH), 32'd2);

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 4) == 0) mask = 4'($urandom_range(0, 15));
            else                           mask = 4'(1 << $urandom_range(0, 3));
            op(mask, 4'($urandom), 8'($urandom), $urandom_range(0, 3) == 0,
               $urandom_range(0, 7) == 0);
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        // Fill to capacity and exercise the overflow bound.
        reset_pulse();
        for (int k = 0; k < 256; k++) op(4'b0010, 4'($urandom), 8'h00, 1'b0, 1'b0);
        chk("fill_depth_lit", 32'(DEPTH), 32'd256);
        op(4'b0010, 4'h1, 8'h00, 1'b0, 1'b0);
        chk("ovf_push_lit", 32'(OVF), 32'd1);
        op(4'b1000, 4'h0, 8'h12, 1'b0, 1'b1);
        chk("ovf_call_lit", 32'(OVF), 32'd1);
        op(4'b0001, 4'h0, 8'h00, 1'b0, 1'b1);
        op(4'b1000, 4'h0, 8'h34, 1'b0, 1'b0);
        chk("ovf_255_lit", 32'(OVF), 32'd1);
        chk("depth_255_lit", 32'(DEPTH), 32'd255);
        for (int k = 0; k < 255; k++) op(4'b0001, 4'h0, 8'h00, 1'b0, 1'b0);
        chk("empty_lit", 32'(DEPTH), 32'd0);
        op(4'b0100, 4'h0, 8'h00, 1'b0, 1'b0);
        chk("unf_ret_lit", 32'(UNF), 32'd1);

        // Reset while CALL is in its first WR cycle.
        @(negedge CLK);
        CALL_REQ = 1'b1; PC_IN = 8'h9D;
        m_dnu = 1'b1;
        e = cur_exp(); e.spc = 1'b1; exp_q.push_back(e);
        e = cur_exp(); e.nsk = 1'b0; e.oe = 1'b1; e.sout = 4'h9; exp_q.push_back(e);
        @(negedge CLK);
        CALL_REQ = 1'b0;
        reset_pulse();
        chk("rst_depth_lit", 32'(DEPTH), 32'd0);
        chk("rst_done_lit", 32'({DONE, BUSY}), 32'd0);
        op(4'b0010, 4'h6, 8'h00, 1'b0, 1'b0);
        op(4'b0001, 4'h0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
